// File: rtl/button_debouncer.sv
// Debounces one raw asynchronous input: two-flop synchroniser, prescaled sample strobe,
// and a four-state FSM that flips `level` after STABLE_COUNT consecutive differing samples.
module button_debouncer #(
  parameter int PRESCALE     = 50000,
  parameter int STABLE_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic update
);

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = $clog2(STABLE_COUNT + 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCNT_MAX = SW'(STABLE_COUNT);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;

  logic          sync1;
  logic          sync2;
  logic [PW-1:0] pcnt;
  logic          strobe;
  logic [SW-1:0] scnt_q;
  logic [SW-1:0] scnt_d;
  logic [SW-1:0] scnt_inc;
  state_t        state_q;
  state_t        state_d;
  logic          level_d;

  // Only sync2 is consumed below; sync1 may go metastable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (strobe) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign strobe   = (pcnt == PCNT_MAX);
  // scnt never exceeds STABLE_COUNT-1 while checking, so the increment cannot wrap.
  assign scnt_inc = scnt_q + SW'(1);

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    level_d = level;
    if (strobe) begin
      case (state_q)
        STABLE_LOW: begin
          if (sync2) begin
            if (STABLE_COUNT == 1) begin
              state_d = STABLE_HIGH;
              level_d = 1'b1;
            end else begin
              state_d = CHECK_HIGH;
              scnt_d  = SW'(1);
            end
          end
        end
        CHECK_HIGH: begin
          if (sync2) begin
            if (scnt_inc == SCNT_MAX) begin
              state_d = STABLE_HIGH;
              level_d = 1'b1;
              scnt_d  = '0;
            end else begin
              scnt_d = scnt_inc;
            end
          end else begin
            state_d = STABLE_LOW;
            scnt_d  = '0;
          end
        end
        STABLE_HIGH: begin
          if (!sync2) begin
            if (STABLE_COUNT == 1) begin
              state_d = STABLE_LOW;
              level_d = 1'b0;
            end else begin
              state_d = CHECK_LOW;
              scnt_d  = SW'(1);
            end
          end
        end
        CHECK_LOW: begin
          if (!sync2) begin
            if (scnt_inc == SCNT_MAX) begin
              state_d = STABLE_LOW;
              level_d = 1'b0;
              scnt_d  = '0;
            end else begin
              scnt_d = scnt_inc;
            end
          end else begin
            state_d = STABLE_HIGH;
            scnt_d  = '0;
          end
        end
        default: begin
          state_d = STABLE_LOW;
          scnt_d  = '0;
          level_d = 1'b0;
        end
      endcase
    end
  end

  // level and update share an edge, so a new level always arrives with its strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE_LOW;
      scnt_q  <= '0;
      level   <= 1'b0;
      update  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      level   <= level_d;
      update  <= strobe;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer (PRESCALE=4, STABLE_COUNT=3): directed scenarios then random
// raw/reset traffic, every cycle checked against a sample-history reference model.
module tb_button_debouncer;

  localparam int P  = 4;
  localparam int SC = 3;

  logic clk = 1'b0;
  logic reset;
  logic raw;
  logic level;
  logic update;

  int n_cmp  = 0;
  int n_fail = 0;

  button_debouncer #(.PRESCALE(P), .STABLE_COUNT(SC)) dut (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw),
    .level  (level),
    .update (update)
  );

  always #5 clk = ~clk;

  // Reference model: level flips once the last SC samples taken since the previous
  // flip all disagree with it. A sample is raw as seen two edges before the strobe edge.
  logic [1:0] exp_q[$];
  logic       hist[$];
  logic       smp_hist[$];
  int         m_n;
  logic       m_level;
  logic       m_smp;
  logic       m_strobe;
  logic       m_all;

  always @(posedge clk) begin
    if (reset) begin
      m_n = 0;
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      smp_hist.delete();
      m_level = 1'b0;
      exp_q.push_back(2'b00);
    end else begin
      m_smp = hist[hist.size() - 2];
      hist.push_back(raw);
      if (hist.size() > 4) void'(hist.pop_front());
      m_n++;
      m_strobe = ((m_n % P) == 0);
      if (m_strobe) begin
        smp_hist.push_back(m_smp);
        if (smp_hist.size() >= SC) begin
          m_all = 1'b1;
          for (int k = 1; k <= SC; k++)
            if (smp_hist[smp_hist.size() - k] == m_level) m_all = 1'b0;
          if (m_all) begin
            m_level = ~m_level;
            smp_hist.delete();
          end
        end
      end
      exp_q.push_back({m_level, m_strobe});
    end
  end

  logic cur_exp_upd;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one cycle and compare both outputs with the model's scoreboard entry.
  task automatic tick();
    logic [1:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      cur_exp_upd = 1'b0;
    end else begin
      e = exp_q.pop_front();
      cur_exp_upd = e[0];
      chk("model_level", level, e[1]);
      chk("model_update", update, e[0]);
    end
  endtask

  // Drive one value for one whole sample period; returns just after its update pulse.
  task automatic sample_period(input logic v);
    bit seen;
    seen = 1'b0;
    raw = v;
    for (int i = 0; i < 2 * P; i++) begin
      tick();
      if (cur_exp_upd) begin
        seen = 1'b1;
        break;
      end
    end
    chk("sample_period_strobe_seen", seen, 1'b1);
  endtask

  // Wait for level to reach target and check the latency window and update coincidence.
  task automatic wait_level(input string tag, input logic target);
    int   lat;
    logic upd_at;
    lat    = 0;
    upd_at = 1'b0;
    for (int i = 1; i <= 2 + SC * P + 2; i++) begin
      tick();
      if (level === target) begin
        lat    = i;
        upd_at = update;
        break;
      end
    end
    chk({tag, "_latency_in_window"}, (lat >= 2 + (SC - 1) * P + 1) && (lat <= 2 + SC * P), 1'b1);
    chk({tag, "_with_update"}, upd_at, 1'b1);
  endtask

  localparam logic [5:0] BOUNCE_SEQ = 6'b111011; // bit k = raw value for sample k
  logic [5:0] bounce_seq;

  initial begin
    reset = 1'b1;
    raw   = 1'b0;
    bounce_seq = BOUNCE_SEQ;

    // Reset and strobe cadence
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_level", level, 1'b0);
      chk("reset_update", update, 1'b0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("cadence_update", update, (i % P) == 0);
      chk("cadence_level", level, 1'b0);
    end

    // Clean press then hold
    raw = 1'b1;
    wait_level("press", 1'b1);
    for (int i = 0; i < 3 * P; i++) begin
      tick();
      chk("press_hold", level, 1'b1);
    end

    // Clean release then hold
    raw = 1'b0;
    wait_level("release", 1'b0);
    for (int i = 0; i < 3 * P; i++) begin
      tick();
      chk("release_hold", level, 1'b0);
    end

    // Bounce rejection: samples 1,1,0,1,1,1
    sample_period(1'b0);
    for (int k = 0; k < 6; k++) begin
      sample_period(bounce_seq[k]);
      chk("bounce_level", level, k == 5);
    end

    // Back to low, then two agreeing high samples, then reset mid-check
    for (int k = 0; k < SC; k++) sample_period(1'b0);
    chk("pre_midcheck_level", level, 1'b0);
    sample_period(1'b1);
    sample_period(1'b1);
    chk("midcheck_level_low", level, 1'b0);
    reset = 1'b1;
    tick();
    chk("midreset_level", level, 1'b0);
    chk("midreset_update", update, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 3 * P; i++) begin
      tick();
      chk("midreset_cadence", update, (i % P) == 0);
      chk("midreset_rise", level, i >= 3 * P);
    end

    // Glitch between strobes from a settled low level
    for (int k = 0; k < SC; k++) sample_period(1'b0);
    chk("pre_glitch_level", level, 1'b0);
    raw = 1'b1;
    tick();
    raw = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      tick();
      chk("glitch_level", level, 1'b0);
    end

    // Random traffic with occasional resets
    for (int s = 0; s < 150; s++) begin
      int hold;
      raw  = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 14);
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      for (int i = 0; i < hold; i++) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces one raw, asynchronous push-button or switch input. It produces a clean `level` and a periodic `update` strobe, which feed the rising-edge detector stage directly downstream. The block synchronises the input, samples it on a prescaled strobe and changes `level` only after `STABLE_COUNT` consecutive agreeing samples. `update` marks every sample instant, so the downstream stage evaluates `level` exactly once per sample period.

## Interface
- `PRESCALE`, default 50000: clock cycles per sample period; legal values are ≥ 2.
- `STABLE_COUNT`, default 4: number of consecutive differing samples needed to flip `level`; legal values are ≥ 1.

- `clk`  input  1  system clock, rising-edge active.
- `reset`  input  1  synchronous, active-high reset.
- `raw`  input  1  undebounced asynchronous input.
- `level`  output  1  debounced level, registered.
- `update`  output  1  one-cycle pulse once per sample period, registered.

## Operation
**Synchroniser**
- Two flops in series, `sync1` then `sync2`; both reset to 0.
- Only `sync2` is used downstream of the synchroniser.

**Prescaler**
- Counter `pcnt`, 0 to PRESCALE-1, width $clog2(PRESCALE); reset value 0.
- Internal `strobe` = (`pcnt` == PRESCALE-1), combinational.
- On `strobe`, `pcnt` wraps to 0; otherwise it increments.

**Stability counter**
- Counter `scnt`, width $clog2(STABLE_COUNT+1); reset value 0.

**FSM states** (reset state: `STABLE_LOW`)
- `STABLE_LOW`: `level`=0. On `strobe` with `sync2`=1:
  - if STABLE_COUNT==1, go to `STABLE_HIGH` and set `level`=1;
  - else go to `CHECK_HIGH` with `scnt`=1.
- `CHECK_HIGH`: `level`=0. On `strobe` with `sync2`=1, `scnt`++.
  - When `scnt` reaches STABLE_COUNT, go to `STABLE_HIGH`, set `level`=1 and clear `scnt`.
  - On `strobe` with `sync2`=0, return to `STABLE_LOW` and clear `scnt`.
- `STABLE_HIGH` and `CHECK_LOW`: mirror images of the two states above, with 0 and 1 swapped.
- Without `strobe`, the state, `scnt` and `level` all hold.

**Outputs**
- `update` <= `strobe` (registered). It is high for exactly one cycle every PRESCALE cycles, regardless of FSM state.
- `level` changes only on the clock edge where `update` goes high, so a new `level` is always presented together with its `update` pulse.

**Reset**
- `reset` has priority over every other input.
- It clears all registers in the same edge, including mid-check and mid-prescale.
- Outputs become `level`=0 and `update`=0 on the first edge where `reset` is sampled high.

## Timing
- Reset values: `level`=0, `update`=0.
- First `update` pulse: the PRESCALE-th cycle after reset is released. Subsequent pulses follow every PRESCALE cycles.
- Synchroniser latency: 2 cycles from a `raw` change to `sync2`.
- Debounce latency from a clean `raw` edge to `level` changing:
  - minimum 2 + (STABLE_COUNT-1)·PRESCALE + 1 cycles;
  - maximum 2 + STABLE_COUNT·PRESCALE cycles.
- Any sample that agrees with the current `level` during a check aborts it. There is no partial credit: the next attempt restarts at `scnt`=1.
- `raw` changes between strobes are invisible; only the values sampled at strobes count.
- `raw` changing in the same cycle as `strobe` is resolved by the synchroniser. The `sync2` value at that edge is the sample.
- `level` never toggles more than once per PRESCALE cycles.
- `level` never toggles without `update` being high in the same cycle.

## Test plan
All scenarios use PRESCALE=4 and STABLE_COUNT=3.
- **Reset and strobe cadence:** hold `raw`=0 and pulse `reset` for 2 cycles, then release. Require `level`=0 throughout, and `update` high in exactly cycles 4, 8, 12, 16 after release and low elsewhere.
- **Clean press:** after reset, drive `raw`=1 and hold it. Require `level` to rise coincident with the 3rd `update` pulse after `sync2`=1, within 2 + 12 cycles of the `raw` edge, and to stay 1 thereafter.
- **Bounce rejection:** from `STABLE_LOW`, drive `raw` high for exactly 2 samples, low for 1, then high for 3. Require `level`=0 through the first 3 samples and `level`=1 on the 6th sample's `update` pulse.
- **Clean release:** from `STABLE_HIGH`, drive `raw`=0 and hold it. Require `level` to fall on the 3rd `update` pulse and no spurious 1 afterwards.
- **Reset mid-check:** enter `CHECK_HIGH` with `scnt`=2, then assert `reset` for 1 cycle while `raw`=1 stays held.
  - Require `level`=0 and `update`=0 after reset.
  - After release, the prescaler restarts with `update` at cycle 4, and `level` rises on the 3rd new `update` pulse.
- **Glitch between strobes:** pulse `raw` high for 1 cycle placed away from any strobe edge. Require `level`=0 and no state change.
